// File: rtl/alu_pkg.sv
// Shared definitions for the limb-serial ALU: op codes, FSM state type, op legality helper.
package alu_pkg;

   localparam logic [2:0] ALU_OP_ADD = 3'b001;
   localparam logic [2:0] ALU_OP_SUB = 3'b010;
   localparam logic [2:0] ALU_OP_AND = 3'b100;
   localparam logic [2:0] ALU_OP_OR  = 3'b101;
   localparam logic [2:0] ALU_OP_XOR = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for the five defined op codes.
   function automatic logic alu_op_legal(input logic [2:0] op);
      logic legal;
      case (op)
         ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR: legal = 1'b1;
         default:                                                   legal = 1'b0;
      endcase
      return legal;
   endfunction

   // True for ops whose carry chain is meaningful (add/sub).
   function automatic logic alu_op_arith(input logic [2:0] op);
      return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
   endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Command/result bus of alu_serial. out_z/out_ovf exist only with ALU_SERIAL_FLAGS_EN.
interface alu_serial_if #(
   parameter int unsigned W = 4,
   parameter int unsigned N = 4
);
   localparam int unsigned DW = N * W;

   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_y;
   logic          out_co;
   logic          out_err;
`ifdef ALU_SERIAL_FLAGS_EN
   logic          out_z;
   logic          out_ovf;
`endif

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
`ifdef ALU_SERIAL_FLAGS_EN
      input  out_z, out_ovf,
`endif
      input  in_ready, out_valid, out_y, out_co, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
`ifdef ALU_SERIAL_FLAGS_EN
      output out_z, out_ovf,
`endif
      output in_ready, out_valid, out_y, out_co, out_err
   );

endinterface

// File: rtl/alu_limb.sv
// Combinational W-bit ALU slice: one limb of the serial datapath.
module alu_limb
   import alu_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] y,
   output logic         co,
   output logic         msb_ci
);

   logic [W-1:0] b_eff;
   logic [W:0]   sum;

   // Sub is add of inverted b; caller supplies the initial carry of 1.
   always_comb begin
      b_eff  = (op == ALU_OP_SUB) ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_eff} + (W+1)'(ci);
      y      = '0;
      co     = 1'b0;
      msb_ci = 1'b0;
      case (op)
         ALU_OP_ADD, ALU_OP_SUB: begin
            y      = sum[W-1:0];
            co     = sum[W];
            msb_ci = a[W-1] ^ b_eff[W-1] ^ sum[W-1];
         end
         ALU_OP_AND: y = a & b;
         ALU_OP_OR:  y = a | b;
         ALU_OP_XOR: y = a ^ b;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Limb-serial multi-word ALU: one W-bit limb per cycle, carry rippled through a register.
// Optional zero/overflow flags are built when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial
   import alu_pkg::*;
#(
   parameter int unsigned W = 4,
   parameter int unsigned N = 4
) (
   input  logic       clk,
   input  logic       reset,
   alu_serial_if.slave bus
);

   localparam int unsigned DW = N * W;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t        state;
   logic [IW-1:0] idx;
   logic          carry;
   logic [2:0]    op_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;

   logic [W-1:0]  a_l;
   logic [W-1:0]  b_l;
   logic [W-1:0]  y_l;
   logic          co_l;
   logic          msb_ci_l;
   logic [DW-1:0] y_next;

   assign a_l = a_q[32'(idx) * W +: W];
   assign b_l = b_q[32'(idx) * W +: W];

   alu_limb #(.W(W)) u_limb (
      .op     (op_q),
      .a      (a_l),
      .b      (b_l),
      .ci     (carry),
      .y      (y_l),
      .co     (co_l),
      .msb_ci (msb_ci_l)
   );

   // Result word with the current limb merged in, used for the write-back and the zero flag.
   always_comb begin
      y_next = bus.out_y;
      y_next[32'(idx) * W +: W] = y_l;
   end

`ifndef ALU_SERIAL_FLAGS_EN
   logic unused_msb_ci;
   assign unused_msb_ci = msb_ci_l;
`endif

   // Control FSM, limb index, carry register and registered result/flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         carry         <= 1'b0;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_y     <= '0;
         bus.out_co    <= 1'b0;
         bus.out_err   <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
         bus.out_z     <= 1'b0;
         bus.out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  op_q         <= bus.in_op;
                  a_q          <= bus.in_a;
                  b_q          <= bus.in_b;
                  idx          <= '0;
                  carry        <= (bus.in_op == ALU_OP_SUB);
                  bus.out_y    <= '0;
                  bus.out_co   <= 1'b0;
                  bus.out_err  <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
                  bus.out_z    <= 1'b0;
                  bus.out_ovf  <= 1'b0;
`endif
                  bus.in_ready <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               bus.out_y <= y_next;
               carry     <= co_l;
               if (idx == LAST) begin
                  bus.out_co    <= co_l;
                  bus.out_err   <= !alu_op_legal(op_q);
`ifdef ALU_SERIAL_FLAGS_EN
                  bus.out_z     <= (y_next == '0);
                  bus.out_ovf   <= alu_op_arith(op_q) ? (msb_ci_l ^ co_l) : 1'b0;
`endif
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial (W=4, N=4); flag checks compiled in with ALU_SERIAL_FLAGS_EN.
module tb_alu_serial;
   import alu_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned N  = 4;
   localparam int unsigned DW = N * W;

   typedef struct {
      logic [DW-1:0] y;
      logic          co;
      logic          err;
      logic          z;
      logic          ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_err = 0;
   int   n_chk = 0;
   int   cyc   = 0;
   int   acc   = 0;
   exp_t sb[$];

   alu_serial_if #(.W(W), .N(N)) bus ();
   alu_serial #(.W(W), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t e;
      logic [DW:0] s;
      e.y = '0; e.co = 1'b0; e.err = 1'b0; e.ovf = 1'b0;
      case (op)
         3'b001: begin
            s     = {1'b0, a} + {1'b0, b};
            e.y   = s[DW-1:0];
            e.co  = s[DW];
            e.ovf = (a[DW-1] == b[DW-1]) && (e.y[DW-1] != a[DW-1]);
         end
         3'b010: begin
            e.y   = a - b;
            e.co  = (a >= b);
            e.ovf = (a[DW-1] != b[DW-1]) && (e.y[DW-1] != a[DW-1]);
         end
         3'b100: e.y = a & b;
         3'b101: e.y = a | b;
         3'b110: e.y = a ^ b;
         default: e.err = 1'b1;
      endcase
      e.z = (e.y == '0);
      return e;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      sb.push_back(model(op, a, b));
   endtask

   // Drive a command and return just after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      drive(op, a, b);
      @(posedge clk);
      #1;
      acc          = cyc;
      bus.in_valid = 1'b0;
   endtask

   // Wait for the result, compare against the scoreboard, stall `hold` cycles, then consume.
   task automatic collect(input int hold);
      exp_t e;
      int   k = 0;
      @(negedge clk);
      while (!bus.out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("latency", 32'(cyc - acc), 32'(N));
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         e = model(3'b001, '0, '0);
      end else begin
         e = sb.pop_front();
      end
      check("out_y", 32'(bus.out_y), 32'(e.y));
      check("out_co", 32'(bus.out_co), 32'(e.co));
      check("out_err", 32'(bus.out_err), 32'(e.err));
`ifdef ALU_SERIAL_FLAGS_EN
      check("out_z", 32'(bus.out_z), 32'(e.z));
      check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_y", 32'(bus.out_y), 32'(e.y));
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("consume_valid", 32'(bus.out_valid), 32'd0);
      check("consume_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_y", 32'(bus.out_y), 32'd0);
      check("rst_out_co", 32'(bus.out_co), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
`ifdef ALU_SERIAL_FLAGS_EN
      check("rst_out_z", 32'(bus.out_z), 32'd0);
      check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif

      // Arithmetic corner cases
      send(ALU_OP_ADD, 16'h00FF, 16'h0001); collect(0);
      send(ALU_OP_ADD, 16'hFFFF, 16'h0001); collect(0);
      send(ALU_OP_ADD, 16'h7FFF, 16'h0001); collect(0);
      send(ALU_OP_SUB, 16'h0000, 16'h0001); collect(0);
      send(ALU_OP_SUB, 16'h8000, 16'h0001); collect(0);
      send(ALU_OP_SUB, 16'h1234, 16'h1234); collect(0);

      // Logic and illegal ops
      send(ALU_OP_AND, 16'hF0F0, 16'h0FF0); collect(0);
      send(ALU_OP_OR,  16'hF0F0, 16'h0FF0); collect(0);
      send(ALU_OP_XOR, 16'hF0F0, 16'h0FF0); collect(0);
      send(3'b111,     16'hF0F0, 16'h0FF0); collect(0);
      send(3'b000,     16'hFFFF, 16'hFFFF); collect(0);
      send(3'b011,     16'h1234, 16'h4321); collect(1);

      // out_ready high during RUN changes nothing
      send(ALU_OP_ADD, 16'h1357, 16'h2468);
      bus.out_ready = 1'b1;
      collect(0);

      // Back-to-back: second command held by the source while busy and stalled
      send(ALU_OP_ADD, 16'hABCD, 16'h1111);
      drive(ALU_OP_SUB, 16'h0005, 16'h0009);
      collect(5);
      @(posedge clk);
      #1;
      acc          = cyc;
      bus.in_valid = 1'b0;
      check("b2b_accepted", 32'(bus.in_ready), 32'd0);
      collect(0);

      // Reset in the middle of RUN discards the operation
      send(ALU_OP_ADD, 16'h1234, 16'h0F0F);
      void'(sb.pop_back());
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_state", 32'(dut.state), 32'(IDLE));
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_out_y", 32'(bus.out_y), 32'd0);
      send(ALU_OP_ADD, 16'h0001, 16'h0001); collect(0);

      // Random mix
      for (int i = 0; i < 8; i++) begin
         send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
         collect(int'($urandom_range(0, 2)));
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
